// File: rtl/adda_pkg.sv
// Shared types and width helpers for the AD/DA streaming front-end.
package adda_pkg;

    // Output path selection; the 2'b11 encoding decodes to FILT.
    typedef enum logic [1:0] {
        FILT = 2'b00,
        BYP  = 2'b01,
        MUTE = 2'b10
    } adda_mode_e;

    // Serial FIR sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MAC  = 2'b01,
        ST_RND  = 2'b10,
        ST_OUT  = 2'b11
    } fir_state_e;

    // Accumulator width: full product plus growth for NTAPS additions.
    function automatic int acc_width(input int dw, input int cw, input int ntaps);
        return dw + cw + $clog2(ntaps);
    endfunction

    // Half an output LSB in accumulator units (unity gain is 2^(CW-2)).
    function automatic int rnd_const(input int cw);
        return 1 << (cw - 3);
    endfunction

    // Map the raw mode pins onto the mode enum.
    function automatic adda_mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return BYP;
            2'b10:   return MUTE;
            default: return FILT;
        endcase
    endfunction

endpackage

// File: rtl/adda_fir_serial.sv
// Serial-MAC FIR: coefficient RAM, circular delay line, one product per
// cycle, then round-half-up and clamp to the output word width.
module adda_fir_serial
    import adda_pkg::*;
#(
    parameter int DW    = 8,
    parameter int NTAPS = 16,
    parameter int CW    = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic signed [DW-1:0]       x,
    input  logic                       coef_we,
    input  logic [$clog2(NTAPS)-1:0]   coef_addr,
    input  logic signed [CW-1:0]       coef_wdata,
    output logic signed [DW-1:0]       y,
    output logic                       y_vld,
    output logic                       y_sat
);

    localparam int AW    = $clog2(NTAPS);
    localparam int ACC_W = acc_width(DW, CW, NTAPS);
    localparam logic signed [CW-1:0]    UNITY = CW'(1 << (CW - 2));
    localparam logic signed [ACC_W-1:0] RND_K = ACC_W'(rnd_const(CW));
    localparam logic signed [ACC_W-1:0] YMAX  = ACC_W'((1 << (DW - 1)) - 1);
    localparam logic signed [ACC_W-1:0] YMIN  = ~YMAX;

    fir_state_e                state;
    logic signed [DW-1:0]      dline [NTAPS];
    logic signed [CW-1:0]      coefs [NTAPS];
    logic [AW-1:0]             wptr;
    logic [AW-1:0]             rptr;
    logic [AW-1:0]             k;
    logic signed [ACC_W-1:0]   acc;
    logic signed [DW+CW-1:0]   prod;
    logic signed [ACC_W-1:0]   acc_rnd;

    // Add half an LSB, then drop the fractional bits of the unity scale.
    function automatic logic signed [ACC_W-1:0] round_acc(input logic signed [ACC_W-1:0] a);
        return (a + RND_K) >>> (CW - 2);
    endfunction

    function automatic logic sat_hit(input logic signed [ACC_W-1:0] r);
        return (r > YMAX) || (r < YMIN);
    endfunction

    function automatic logic signed [DW-1:0] sat_val(input logic signed [ACC_W-1:0] r);
        if (r > YMAX)
            return {1'b0, {(DW-1){1'b1}}};
        else if (r < YMIN)
            return {1'b1, {(DW-1){1'b0}}};
        else
            return r[DW-1:0];
    endfunction

    assign prod    = dline[rptr] * coefs[k];
    assign acc_rnd = round_acc(acc);
    assign y       = sat_val(acc_rnd);
    assign y_sat   = sat_hit(acc_rnd);
    assign y_vld   = (state == ST_RND);

    // Coefficient RAM; writes land on the next edge whatever the sequencer is doing.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++)
                coefs[i] <= (i == 0) ? UNITY : '0;
        end else if (coef_we) begin
            coefs[coef_addr] <= coef_wdata;
        end
    end

    // Sample write, MAC sequencing over the delay line, then round and output slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            acc   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            k     <= '0;
            for (int i = 0; i < NTAPS; i++)
                dline[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dline[wptr] <= x;
                        rptr        <= wptr;
                        wptr        <= wptr + AW'(1);
                        k           <= '0;
                        acc         <= '0;
                        state       <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc  <= acc + ACC_W'(prod);
                    rptr <= rptr - AW'(1);
                    k    <= k + AW'(1);
                    if (k == AW'(NTAPS - 1))
                        state <= ST_RND;
                end
                ST_RND:  state <= ST_OUT;
                ST_OUT:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/adda_stream.sv
// AD/DA streaming front-end: phase counter, ADC/DAC clock generation,
// offset-binary conversion, mode mux and sticky saturation flag around
// the serial FIR.
module adda_stream
    import adda_pkg::*;
#(
    parameter int DW    = 8,
    parameter int NTAPS = 16,
    parameter int CW    = 12,
    parameter int DIV   = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       adclk,
    input  logic [DW-1:0]              addata,
    output logic                       daclk,
    output logic [DW-1:0]              dadata,
    input  logic [1:0]                 mode,
    input  logic                       coef_we,
    input  logic [$clog2(NTAPS)-1:0]   coef_addr,
    input  logic signed [CW-1:0]       coef_wdata,
    output logic                       sample_stb,
    output logic                       sat_flag,
    input  logic                       sat_clr
);

    if (DIV < NTAPS + 4) begin : g_div_check
        $error("adda_stream: DIV must be at least NTAPS+4");
    end
    if ((NTAPS < 2) || ((NTAPS & (NTAPS - 1)) != 0)) begin : g_ntaps_check
        $error("adda_stream: NTAPS must be a power of two >= 2");
    end

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] AD_HIGH  = CNT_W'(DIV / 2);
    localparam logic [CNT_W-1:0] DA_ON    = CNT_W'((NTAPS + 3) % DIV);
    localparam logic [CNT_W-1:0] DA_OFF   = CNT_W'((NTAPS + 3 + DIV / 2) % DIV);
    localparam logic [DW-1:0]    MID      = {1'b1, {(DW-1){1'b0}}};

    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 start;
    logic signed [DW-1:0] x_tc;
    logic [DW-1:0]        cap_p0;
    adda_mode_e           mode_p0;
    logic signed [DW-1:0] y;
    logic                 y_vld;
    logic                 y_sat;

    assign cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    assign start   = (cnt == '0);
    assign x_tc    = {~addata[DW-1], addata[DW-2:0]};

    adda_fir_serial #(
        .DW    (DW),
        .NTAPS (NTAPS),
        .CW    (CW)
    ) u_fir (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .x          (x_tc),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .y          (y),
        .y_vld      (y_vld),
        .y_sat      (y_sat)
    );

    // Phase counter with registered ADC and DAC clocks decoded from the next phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            adclk <= 1'b0;
            daclk <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            adclk <= (cnt_nxt != '0) && (cnt_nxt <= AD_HIGH);
            if (cnt_nxt == DA_ON)
                daclk <= 1'b1;
            else if (cnt_nxt == DA_OFF)
                daclk <= 1'b0;
        end
    end

    // Hold the raw ADC word and the selected mode for the whole sample period.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_p0  <= MID;
            mode_p0 <= FILT;
        end else if (start) begin
            cap_p0  <= addata;
            mode_p0 <= decode_mode(mode);
        end
    end

    // DAC word update, load strobe and sticky saturation (set beats clear).
    always_ff @(posedge clk) begin
        if (reset) begin
            dadata     <= MID;
            sample_stb <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            sample_stb <= y_vld;
            if (y_vld) begin
                case (mode_p0)
                    BYP:     dadata <= cap_p0;
                    MUTE:    dadata <= MID;
                    default: dadata <= {~y[DW-1], y[DW-2:0]};
                endcase
            end
            if (y_vld && y_sat && (mode_p0 == FILT))
                sat_flag <= 1'b1;
            else if (sat_clr)
                sat_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adda_stream.sv
// Scoreboard bench for adda_stream with DW=8, NTAPS=16, CW=12, DIV=32.
module tb_adda_stream;

    localparam int DIV = 32;

    logic              clk;
    logic              reset;
    logic              adclk;
    logic [7:0]        addata;
    logic              daclk;
    logic [7:0]        dadata;
    logic [1:0]        mode;
    logic              coef_we;
    logic [3:0]        coef_addr;
    logic signed [11:0] coef_wdata;
    logic              sample_stb;
    logic              sat_flag;
    logic              sat_clr;

    int                checks = 0;
    int                errors = 0;
    int                ph = 0;
    logic [7:0]        exp_q [$];
    logic [7:0]        exp_v;

    adda_stream #(
        .DW    (8),
        .NTAPS (16),
        .CW    (12),
        .DIV   (DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .adclk      (adclk),
        .addata     (addata),
        .daclk      (daclk),
        .dadata     (dadata),
        .mode       (mode),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .sample_stb (sample_stb),
        .sat_flag   (sat_flag),
        .sat_clr    (sat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference sample phase.
    always @(posedge clk) begin
        if (reset) ph <= 0;
        else       ph <= (ph == DIV - 1) ? 0 : ph + 1;
    end

    // Monitor: every DAC strobe must land at phase 18 and match the next expected word.
    always @(negedge clk) begin
        if (!reset && sample_stb) begin
            checks++;
            if (ph != 18) begin
                errors++;
                $display("FAIL stb_phase act=%0d req=18", ph);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_stb dadata=%02h req=none", dadata);
            end else begin
                exp_v = exp_q.pop_front();
                if (dadata !== exp_v) begin
                    errors++;
                    $display("FAIL dadata act=%02h req=%02h", dadata, exp_v);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end
    endtask

    task automatic to_ph(input int p);
        int n;
        n = 0;
        while (ph != p && n < 2 * DIV) begin
            @(negedge clk);
            n++;
        end
        if (ph != p) begin
            checks++;
            errors++;
            $display("FAIL to_ph act=%0d req=%0d", ph, p);
        end
    endtask

    task automatic put_sample(input logic [7:0] a, input logic [1:0] m,
                              input logic [7:0] e, input bit push);
        to_ph(0);
        addata = a;
        mode   = m;
        if (push) exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic wr_coef(input int a, input logic [11:0] v);
        coef_we    = 1'b1;
        coef_addr  = a[3:0];
        coef_wdata = v;
        @(negedge clk);
        coef_we    = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        addata     = 8'hC0;
        mode       = 2'b00;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        sat_clr    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dadata", dadata, 8'h80);
        chk("rst_adclk", adclk, 0);
        chk("rst_daclk", daclk, 0);
        chk("rst_stb", sample_stb, 0);
        chk("rst_sat", sat_flag, 0);
        reset = 1'b0;

        // Identity filter after reset, with clock phase checks.
        put_sample(8'hC0, 2'b00, 8'hC0, 1);
        chk("adclk_ph1", adclk, 1);
        to_ph(16); chk("adclk_ph16", adclk, 1);
        to_ph(17); chk("adclk_ph17", adclk, 0);
        chk("dadata_pre_out", dadata, 8'h80);
        to_ph(18); chk("daclk_ph18", daclk, 0);
        to_ph(19); chk("daclk_ph19", daclk, 1);
        chk("stb_ph19", sample_stb, 0);
        put_sample(8'hC0, 2'b00, 8'hC0, 1);
        chk("daclk_wrap_ph1", daclk, 1);
        to_ph(3); chk("daclk_ph3", daclk, 0);

        // Two unity taps: saturation both ways and sticky flag behaviour.
        to_ph(20); wr_coef(1, 12'h400);
        put_sample(8'hFF, 2'b00, 8'hFF, 1);
        to_ph(17); chk("sat_before", sat_flag, 0);
        to_ph(18); chk("sat_set", sat_flag, 1);
        put_sample(8'hFF, 2'b00, 8'hFF, 1);
        put_sample(8'h00, 2'b00, 8'h7F, 1);
        put_sample(8'h00, 2'b00, 8'h00, 1);
        to_ph(20);
        sat_clr = 1'b1; @(negedge clk); sat_clr = 1'b0;
        chk("sat_cleared", sat_flag, 0);
        put_sample(8'h00, 2'b00, 8'h00, 1);
        to_ph(17);
        sat_clr = 1'b1; @(negedge clk); sat_clr = 1'b0;
        chk("sat_set_wins", sat_flag, 1);

        // Half-gain tap: rounding of +/-0.5.
        to_ph(20); wr_coef(0, 12'h200); wr_coef(1, 12'h000);
        put_sample(8'h81, 2'b00, 8'h81, 1);
        put_sample(8'h7F, 2'b00, 8'h80, 1);
        put_sample(8'h81, 2'b00, 8'h81, 1);

        // Reset during MAC aborts the sample.
        put_sample(8'hC0, 2'b00, 8'h00, 0);
        to_ph(8);
        chk("adclk_ph8", adclk, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_dadata", dadata, 8'h80);
        chk("mid_rst_adclk", adclk, 0);
        chk("mid_rst_daclk", daclk, 0);
        chk("mid_rst_stb", sample_stb, 0);
        chk("mid_rst_sat", sat_flag, 0);
        reset = 1'b0;
        put_sample(8'h80, 2'b00, 8'h80, 1);

        // Single delayed tap at index 3; mode 11 also filters.
        to_ph(20); wr_coef(0, 12'h000); wr_coef(3, 12'h400);
        put_sample(8'hC0, 2'b00, 8'h80, 1);
        put_sample(8'h80, 2'b00, 8'h80, 1);
        put_sample(8'h80, 2'b00, 8'h80, 1);
        put_sample(8'h80, 2'b00, 8'hC0, 1);
        put_sample(8'h80, 2'b11, 8'h80, 1);

        // Bypass never flags saturation even with a saturating filter.
        to_ph(20); wr_coef(3, 12'h000); wr_coef(0, 12'h400); wr_coef(1, 12'h400);
        put_sample(8'hFF, 2'b01, 8'hFF, 1);
        put_sample(8'hFF, 2'b01, 8'hFF, 1);
        to_ph(20); chk("byp_no_sat", sat_flag, 0);
        wr_coef(0, 12'h000); wr_coef(1, 12'h000);

        // Bypass, mute and mid-sample mode change.
        put_sample(8'h37, 2'b01, 8'h37, 1);
        put_sample(8'hA5, 2'b01, 8'hA5, 1);
        put_sample(8'h5A, 2'b01, 8'h5A, 1);
        to_ph(5); mode = 2'b10;
        put_sample(8'h12, 2'b10, 8'h80, 1);
        put_sample(8'h12, 2'b00, 8'h80, 1);

        to_ph(20);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adda_stream.md
# adda_stream

Parametrised AD/DA streaming front-end: drives the ADC and DAC sample clocks, captures offset-binary ADC words, and runs them through a run-time-programmable serial-MAC FIR. It rounds and saturates the result and returns it to the DAC in offset binary. It replaces the fixed 8-bit adda/PLL/filter top. A single fast `clk` with an internal sample divider replaces the PLL-derived filter clock.

## Interface
- `DW`, 8: ADC/DAC word width.
- `NTAPS`, 16: FIR length, power of two, ≥2.
- `CW`, 12: signed coefficient width; unity gain = 2^(CW-2).
- `DIV`, 32: `clk` cycles per sample; elaboration error if `DIV < NTAPS+4`.

- `clk`  in  1  the only clock.
- `reset`  in  1  synchronous, active-high.
- `adclk`  out  1  ADC sample clock.
- `addata`  in  DW  ADC data, offset binary.
- `daclk`  out  1  DAC load clock.
- `dadata`  out  DW  DAC data, offset binary.
- `mode`  in  2  00/11 filter, 01 bypass, 10 mute.
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  log2(NTAPS)  tap index.
- `coef_wdata`  in  CW  signed coefficient.
- `sample_stb`  out  1  one-cycle pulse when `dadata` updates.
- `sat_flag`  out  1  sticky saturation indicator.
- `sat_clr`  in  1  clears `sat_flag`.

## Operation
- Phase counter `cnt` runs 0..DIV-1 and wraps.
- At cnt==0: register `addata`, invert the MSB (convert to two's complement), and write it into the circular delay line at `wptr`. `wptr` then advances modulo NTAPS.
- FSM states:
  - IDLE: leave at cnt==0 → MAC.
  - MAC: exactly NTAPS cycles, cnt 1..NTAPS. Computes acc += x[n-k]·h[k] for k=0..NTAPS-1, one product per cycle. acc width = DW+CW+log2(NTAPS), cleared on entry. → RND.
  - RND: one cycle. y = (acc + 2^(CW-3)) >>> (CW-2), i.e. round-half-up. Clamp y to [-2^(DW-1), 2^(DW-1)-1]. If clamped, set `sat_flag`. → OUT.
  - OUT: one cycle. Register `dadata` = y with MSB inverted; pulse `sample_stb`. → IDLE.
- `mode` is sampled at cnt==0 and held for that sample.
  - Bypass: `dadata` = captured word unchanged.
  - Mute: `dadata` = 2^(DW-1) (midscale).
  - In both modes the MAC still runs and `sample_stb` timing is unchanged. Saturation is only flagged in filter mode.
- Coefficient writes take effect on the next edge, in any state. A write during MAC may produce one sample computed with mixed old and new coefficients; this is accepted.
- `sat_flag`: if saturation and `sat_clr` occur in the same cycle, set wins.

## Timing
- Reset values:
  - `cnt`=0, FSM=IDLE, `wptr`=0, delay line all 0, acc=0.
  - h[0]=2^(CW-2), all other taps 0, giving an identity filter.
  - `dadata`=2^(DW-1), `adclk`=0, `daclk`=0, `sample_stb`=0, `sat_flag`=0.
- `adclk`: registered; high for cnt∈[1, DIV/2], low otherwise.
- `dadata` and `sample_stb` are visible at cnt==NTAPS+2. Latency is NTAPS+2 cycles from the capture edge.
- `daclk`: registered; rises at cnt==NTAPS+3 and stays high DIV/2 cycles, with the window wrapping modulo DIV.
- Reset asserted mid-MAC aborts the sample: all state returns to reset values and `dadata` does not change until the first full sample after release.

## Structure
- Package `adda_pkg` holds:
  - the mode enum (FILT, BYP, MUTE);
  - the FSM state enum;
  - width helper functions for acc width and the rounding constant.
- Sub-module `adda_fir_serial` holds the coefficient RAM, delay line, MAC FSM and round/saturate logic. The top level keeps the phase counter, clock generation, offset-binary conversion and mode mux.

## Test plan
All scenarios use DW=8, NTAPS=16, CW=12, DIV=32.
- Reset only, `addata`=0xC0 constant → `dadata`=0x80 until the first OUT. After that `dadata`=0xC0, with `sample_stb` at cnt==18 and `daclk` rising at cnt 19.
- Load h[0]=h[1]=0x400, `addata`=0xFF steady → `dadata`=0xFF and `sat_flag`=1. Then `addata`=0x00 → `dadata`=0x00. Pulse `sat_clr` → `sat_flag`=0 unless saturation is still occurring.
- Load h[0]=0x200, others 0:
  - `addata`=0x81 → `dadata`=0x81 (+0.5 rounds up).
  - `addata`=0x7F → `dadata`=0x80 (-0.5 rounds to 0).
- Load h[3]=0x400, others 0; apply one sample of 0xC0 then 0x80 → 0xC0 appears exactly 3 samples later, and all other outputs are 0x80.
- `mode`=01 with h all 0 → `dadata` = `addata`. `mode`=10 → `dadata`=0x80. Change `mode` mid-sample → takes effect at the next cnt==0.
- Assert `reset` at cnt==8 during MAC → the next cycle shows all reset values. The first new `sample_stb` comes at cnt==18 of the first complete sample after release.
